// File: rtl/chip_link_pkg.sv
// Shared types and constants for the chip memory link: FSM states, transfer
// direction encoding and the address/pad/memory-word widths.
package chip_link_pkg;

  localparam int unsigned AX_W   = 12;
  localparam int unsigned PAD_W  = 128;
  localparam int unsigned WORD_W = 256;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADR1,
    ADR2,
    ACK,
    RD_LO,
    RD_HI,
    WR
  } link_state_t;

endpackage

// File: rtl/chip_link_mem.sv
// 256-bit word memory: one write port shared by chip and host (chip wins),
// an asynchronous chip read port and a registered host read port.
module chip_link_mem
  import chip_link_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_chip_we,
  input  logic [$clog2(DEPTH)-1:0] i_chip_addr,
  input  logic [WORD_W-1:0]        i_chip_wdata,
  input  logic                     i_host_we,
  input  logic [$clog2(DEPTH)-1:0] i_host_addr,
  input  logic [WORD_W-1:0]        i_host_wdata,
  output logic [WORD_W-1:0]        o_chip_rdata,
  output logic [WORD_W-1:0]        o_host_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_host_rdata;

  always_ff @(posedge clk) begin
    if (i_chip_we) begin
      r_mem[i_chip_addr] <= i_chip_wdata;
    end else if (i_host_we) begin
      r_mem[i_host_addr] <= i_host_wdata;
    end
    r_host_rdata <= r_mem[i_host_addr];
  end

  assign o_chip_rdata = r_mem[i_chip_addr];
  assign o_host_rdata = r_host_rdata;

endmodule

// File: rtl/chip_mem_link.sv
// Chip-to-memory link: 3-word address phase, ACK delay, 2x128-bit beats per
// 256-bit word. Optional protocol checker enabled by CHIP_LINK_ERRCHK_EN.
module chip_mem_link
  import chip_link_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned AXREADY_DLY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_or_store,
  input  logic [AX_W-1:0]              axaddr_and_axlen,
  input  logic                         axvalid,
  input  logic                         rready_or_wvalid,
  input  logic                         done,
  input  logic [PAD_W-1:0]             data_i,
  output logic                         single_rate,
  output logic                         start,
  output logic                         start_store_byte4,
  output logic                         axready,
  output logic                         rvalid_or_wready,
  output logic [PAD_W-1:0]             data_o,
  output logic                         data_oe,
  input  logic                         start_trig,
  input  logic                         store_byte4_trig,
  input  logic                         host_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] host_addr,
  input  logic [WORD_W-1:0]            host_wdata,
  output logic [WORD_W-1:0]            host_rdata,
  output logic                         done_flag,
  output logic [15:0]                  txn_count,
  output logic                         err
);

  localparam int unsigned AW     = $clog2(MEM_DEPTH);
  localparam logic [15:0] LP_DLY = 16'(AXREADY_DLY);

  link_state_t       r_state, w_next;
  logic [27:0]       r_addr;
  logic              r_dir;
  logic [15:0]       r_dly;
  logic [AW-1:0]     r_ptr;
  logic [8:0]        r_beats;
  logic [PAD_W-1:0]  r_lo_q;
  logic              r_start, r_sb4, r_done_flag;
  logic [15:0]       r_txn;

  logic              w_chip_we;
  logic [WORD_W-1:0] w_chip_rdata;
  logic              w_axready, w_rvw, w_oe;
  logic [PAD_W-1:0]  w_data_o;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_axready = 1'b0;
    w_rvw     = 1'b0;
    w_oe      = 1'b0;
    w_data_o  = '0;
    w_chip_we = 1'b0;
    case (r_state)
      IDLE: if (axvalid) w_next = ADR1;
      ADR1: w_next = ADR2;
      ADR2: w_next = ACK;
      ACK: begin
        if (r_dly == LP_DLY) begin
          w_axready = 1'b1;
          w_next    = (r_dir == DIR_STORE) ? WR : RD_LO;
        end
      end
      RD_LO: begin
        w_oe     = (load_or_store == DIR_LOAD);
        w_data_o = w_chip_rdata[PAD_W-1:0];
        if (rready_or_wvalid) w_next = RD_HI;
      end
      RD_HI: begin
        w_oe     = (load_or_store == DIR_LOAD);
        w_data_o = w_chip_rdata[WORD_W-1:PAD_W];
        w_rvw    = 1'b1;
        w_next   = (r_beats == 9'd1) ? IDLE : RD_LO;
      end
      WR: begin
        w_rvw = 1'b1;
        if (rready_or_wvalid) begin
          w_chip_we = 1'b1;
          if (r_beats == 9'd1) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Word pointer is taken from the full 28-bit address once ACK completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_dir       <= DIR_LOAD;
      r_dly       <= '0;
      r_ptr       <= '0;
      r_beats     <= '0;
      r_lo_q      <= '0;
      r_start     <= 1'b0;
      r_sb4       <= 1'b0;
      r_done_flag <= 1'b0;
      r_txn       <= '0;
    end else begin
      r_start <= start_trig;
      r_sb4   <= store_byte4_trig;
      if (start_trig)  r_done_flag <= 1'b0;
      else if (done)   r_done_flag <= 1'b1;
      if (r_state != IDLE && w_next == IDLE && r_txn != 16'hFFFF)
        r_txn <= r_txn + 16'd1;
      case (r_state)
        IDLE: if (axvalid) r_addr[11:0] <= axaddr_and_axlen;
        ADR1: r_addr[23:12] <= axaddr_and_axlen;
        ADR2: begin
          r_addr[27:24] <= axaddr_and_axlen[3:0];
          r_beats       <= {1'b0, axaddr_and_axlen[11:4]} + 9'd1;
          r_dir         <= load_or_store;
          r_dly         <= '0;
        end
        ACK: begin
          if (r_dly == LP_DLY) r_ptr <= AW'(r_addr >> 5);
          else                 r_dly <= r_dly + 16'd1;
        end
        RD_HI: begin
          r_ptr   <= r_ptr + AW'(1);
          r_beats <= r_beats - 9'd1;
        end
        WR: begin
          r_lo_q <= data_i;
          if (rready_or_wvalid) begin
            r_ptr   <= r_ptr + AW'(1);
            r_beats <= r_beats - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHIP_LINK_ERRCHK_EN
  logic r_err;
  logic w_err_evt;

  always_comb begin
    w_err_evt = 1'b0;
    if (axvalid && r_state != IDLE) w_err_evt = 1'b1;
    if (r_state == WR && rready_or_wvalid && load_or_store == DIR_LOAD) w_err_evt = 1'b1;
    if ((r_state == ACK || r_state == RD_LO || r_state == RD_HI || r_state == WR) &&
        load_or_store != r_dir) w_err_evt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  chip_link_mem #(
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk          (clk),
    .i_chip_we    (w_chip_we),
    .i_chip_addr  (r_ptr),
    .i_chip_wdata ({data_i, r_lo_q}),
    .i_host_we    (host_we),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_chip_rdata (w_chip_rdata),
    .o_host_rdata (host_rdata)
  );

  assign single_rate       = 1'b1;
  assign start             = r_start;
  assign start_store_byte4 = r_sb4;
  assign axready           = w_axready;
  assign rvalid_or_wready  = w_rvw;
  assign data_o            = w_data_o;
  assign data_oe           = w_oe;
  assign done_flag         = r_done_flag;
  assign txn_count         = r_txn;

endmodule
